// File: rtl/mmio_io_bridge.sv
// Memory-mapped I/O peripheral: debounced inputs with sticky edge flags, LFSR
// random source, tone register with auto-off timer and an LED register.

module mmio_debounce_lane #(
  parameter int DEBOUNCE = 250000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic deb,
  output logic rise
);
  localparam int CW = $clog2(DEBOUNCE + 1);

  logic          s1, s2;
  logic [CW-1:0] cnt;
  logic          accept;

  // s2 must disagree with deb for DEBOUNCE consecutive cycles before it is taken
  assign accept = (s2 != deb) && (cnt == CW'(DEBOUNCE - 1));
  assign rise   = accept && s2;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      deb <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == deb) begin
        cnt <= '0;
      end else if (accept) begin
        cnt <= '0;
        deb <= s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module mmio_io_bridge #(
  parameter int          N_IN      = 4,
  parameter int          DEBOUNCE  = 250000,
  parameter int          RAND_W    = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          TONE_W    = 4,
  parameter int          LED_W     = 15,
  parameter int          TICK_DIV  = 50000,
  parameter int          DUR_W     = 16,
  parameter int          IN_ADDR   = 1000,
  parameter int          EDGE_ADDR = 1001,
  parameter int          RAND_ADDR = 2000,
  parameter int          TONE_ADDR = 3000,
  parameter int          DUR_ADDR  = 3001,
  parameter int          LED_ADDR  = 3002,
  parameter int          STAT_ADDR = 3003
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       addr,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [31:0]       wr_data,
  output logic [31:0]       rd_data,
  output logic              hit,
  input  logic [N_IN-1:0]   in_raw,
  output logic [TONE_W-1:0] tone,
  output logic              tone_en,
  output logic [LED_W-1:0]  led
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [N_IN-1:0]  deb, rise, flags;
  logic [15:0]      lfsr;
  logic [DUR_W-1:0] dur, ticks;
  logic [PW-1:0]    presc;
  logic             active;
  logic             rd_sel, rd_match;
  logic [31:0]      rd_val;
  logic [TONE_W-1:0] tone_wr;
  logic             unused_wr;

  assign unused_wr = ^wr_data;
  assign tone_wr   = wr_data[TONE_W-1:0];
  assign rd_sel    = rd_en && !wr_en;

  for (genvar i = 0; i < N_IN; i++) begin : g_lane
    mmio_debounce_lane #(.DEBOUNCE(DEBOUNCE)) u_lane (
      .clock (clock),
      .reset (reset),
      .raw   (in_raw[i]),
      .deb   (deb[i]),
      .rise  (rise[i])
    );
  end

  always_comb begin
    rd_match = 1'b1;
    rd_val   = '0;
    if      (addr == 32'(IN_ADDR))   rd_val = 32'(deb);
    else if (addr == 32'(EDGE_ADDR)) rd_val = 32'(flags);
    else if (addr == 32'(RAND_ADDR)) rd_val = 32'(lfsr[RAND_W-1:0]);
    else if (addr == 32'(TONE_ADDR)) rd_val = 32'(tone);
    else if (addr == 32'(DUR_ADDR))  rd_val = 32'(dur);
    else if (addr == 32'(LED_ADDR))  rd_val = 32'(led);
    else if (addr == 32'(STAT_ADDR)) rd_val = {30'b0, active, tone_en};
    else                             rd_match = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data <= '0;
      hit     <= 1'b0;
      flags   <= '0;
      lfsr    <= LFSR_SEED;
      led     <= '0;
      dur     <= '0;
      tone    <= '0;
      tone_en <= 1'b0;
      ticks   <= '0;
      presc   <= '0;
      active  <= 1'b0;
    end else begin
      hit     <= rd_sel && rd_match;
      rd_data <= (rd_sel && rd_match) ? rd_val : 32'd0;
      lfsr    <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      // a rise landing on the clearing read survives it
      flags   <= ((rd_sel && addr == 32'(EDGE_ADDR)) ? '0 : flags) | rise;

      if (wr_en && addr == 32'(LED_ADDR)) led <= wr_data[LED_W-1:0];
      if (wr_en && addr == 32'(DUR_ADDR)) dur <= wr_data[DUR_W-1:0];

      if (wr_en && addr == 32'(TONE_ADDR)) begin
        tone    <= tone_wr;
        tone_en <= |tone_wr;
        presc   <= '0;
        ticks   <= dur;
        active  <= (|tone_wr) && (|dur);
      end else if (active) begin
        if (presc == PW'(TICK_DIV - 1)) begin
          presc <= '0;
          ticks <= ticks - 1'b1;
          if (ticks == DUR_W'(1)) begin
            tone    <= '0;
            tone_en <= 1'b0;
            active  <= 1'b0;
          end
        end else begin
          presc <= presc + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_mmio_io_bridge.sv
// Directed bench for mmio_io_bridge with a cycle-level behavioural model
// compared every cycle, plus literal expectations at key points.

module tb_mmio_io_bridge;
  localparam int N_IN = 4, DEB = 4, TD = 10;

  logic        clock = 1'b0, reset = 1'b1;
  logic [31:0] addr = '0, wr_data = '0;
  logic        rd_en = 1'b0, wr_en = 1'b0;
  logic [N_IN-1:0] in_raw = '0;
  logic [31:0] rd_data;
  logic        hit, tone_en;
  logic [3:0]  tone;
  logic [14:0] led;

  int total = 0, bad = 0;

  mmio_io_bridge #(.N_IN(N_IN), .DEBOUNCE(DEB), .TICK_DIV(TD)) dut (
    .clock(clock), .reset(reset), .addr(addr), .rd_en(rd_en), .wr_en(wr_en),
    .wr_data(wr_data), .rd_data(rd_data), .hit(hit), .in_raw(in_raw),
    .tone(tone), .tone_en(tone_en), .led(led)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // behavioural model: state as seen after each rising edge
  int          cyc = 0;
  longint      m_exp = 0;
  logic [31:0] m_rd = '0;
  logic        m_hit = 0, m_en = 0, m_active = 0;
  logic [3:0]  m_tone = '0, m_flags = '0, m_deb = '0, h1 = '0, h2 = '0;
  logic [14:0] m_led = '0;
  logic [15:0] m_dur = '0, m_lfsr = 16'hACE1;
  int          run [N_IN];

  always @(posedge clock) begin
    logic [31:0] v;
    logic        mt, rdok;
    logic [3:0]  newedge;
    cyc++;
    if (reset) begin
      m_rd = '0; m_hit = 0; m_en = 0; m_active = 0; m_tone = '0; m_flags = '0;
      m_deb = '0; h1 = '0; h2 = '0; m_led = '0; m_dur = '0; m_lfsr = 16'hACE1;
      for (int c = 0; c < N_IN; c++) run[c] = 0;
    end else begin
      mt = 1'b1;
      case (addr)
        32'd1000: v = 32'(m_deb);
        32'd1001: v = 32'(m_flags);
        32'd2000: v = 32'(m_lfsr & 16'hF);
        32'd3000: v = 32'(m_tone);
        32'd3001: v = 32'(m_dur);
        32'd3002: v = 32'(m_led);
        32'd3003: v = {30'b0, m_active, m_en};
        default:  begin v = '0; mt = 1'b0; end
      endcase
      rdok  = rd_en && !wr_en && mt;
      m_hit = rdok;
      m_rd  = rdok ? v : 32'd0;

      newedge = '0;
      for (int c = 0; c < N_IN; c++) begin
        if (h2[c] != m_deb[c]) begin
          run[c]++;
          if (run[c] == DEB) begin
            m_deb[c] = h2[c];
            run[c] = 0;
            if (h2[c]) newedge[c] = 1'b1;
          end
        end else run[c] = 0;
      end
      h2 = h1; h1 = in_raw;
      m_flags = ((rdok && addr == 32'd1001) ? 4'h0 : m_flags) | newedge;
      m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0);

      if (m_active && longint'(cyc) == m_exp) begin
        m_tone = '0; m_en = 0; m_active = 0;
      end
      if (wr_en && addr == 32'd3002) m_led = wr_data[14:0];
      if (wr_en && addr == 32'd3001) m_dur = wr_data[15:0];
      if (wr_en && addr == 32'd3000) begin
        m_tone = wr_data[3:0];
        m_en = (m_tone != 0);
        m_active = m_en && (m_dur != 0);
        m_exp = longint'(cyc) + longint'(m_dur) * TD;
      end
    end
  end

  always @(negedge clock) begin
    if (cyc > 0) begin
      chk("model rd_data", rd_data, m_rd);
      chk("model hit", 32'(hit), 32'(m_hit));
      chk("model tone", 32'(tone), 32'(m_tone));
      chk("model tone_en", 32'(tone_en), 32'(m_en));
      chk("model led", 32'(led), 32'(m_led));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic h);
    addr = a; rd_en = 1'b1; wr_en = 1'b0;
    tick();
    d = rd_data; h = hit;
    rd_en = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] dv);
    addr = a; wr_data = dv; wr_en = 1'b1; rd_en = 1'b0;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic        h;
    int          n;
    logic [31:0] rexp [4];
    rexp[0] = 32'h1; rexp[1] = 32'h0; rexp[2] = 32'h8; rexp[3] = 32'hC;

    #1;
    repeat (3) tick();
    chk("reset tone", 32'(tone), 0);
    chk("reset tone_en", 32'(tone_en), 0);
    chk("reset led", 32'(led), 0);
    chk("reset hit", 32'(hit), 0);

    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd(32'd2000, d, h);
      chk("rand value", d, rexp[i]);
      chk("rand hit", 32'(h), 1);
    end
    rd(32'd1002, d, h);
    chk("unmapped hit", 32'(h), 0);

    // short glitch on ch2 is rejected
    in_raw = 4'b0100;
    repeat (3) tick();
    in_raw = 4'b0000;
    repeat (10) tick();
    rd(32'd1000, d, h);  chk("glitch in", d, 0);
    rd(32'd1001, d, h);  chk("glitch edge", d, 0);

    in_raw = 4'b0100;
    repeat (8) tick();
    rd(32'd1000, d, h);  chk("debounced in", d, 32'h4);
    rd(32'd1001, d, h);  chk("edge ch2", d, 32'h4);
    rd(32'd1001, d, h);  chk("edge cleared", d, 0);

    // ch0 rises on the very edge that reads/clears the ch1 flag
    in_raw = 4'b0110;
    repeat (8) tick();
    in_raw = 4'b0111;
    repeat (5) tick();
    rd(32'd1001, d, h);  chk("race edge read", d, 32'h2);
    rd(32'd1001, d, h);  chk("race edge kept", d, 32'h1);
    rd(32'd1000, d, h);  chk("in all three", d, 32'h7);

    wr(32'd3001, 32'd3);
    wr(32'd3000, 32'd5);
    chk("tone set", 32'(tone), 5);
    n = 0;
    while (tone_en === 1'b1 && n < 100) begin n++; tick(); end
    chk("tone duration", 32'(n), 30);
    chk("tone off", 32'(tone), 0);

    wr(32'd3000, 32'd5);
    repeat (9) tick();
    rd(32'd3003, d, h);  chk("stat mid", d, 32'h3);
    repeat (40) tick();
    rd(32'd3003, d, h);  chk("stat expired", d, 0);

    wr(32'd3001, 32'd0);
    wr(32'd3000, 32'd9);
    repeat (1005) tick();
    chk("hold tone_en", 32'(tone_en), 1);
    chk("hold tone", 32'(tone), 9);
    wr(32'd3000, 32'd0);
    chk("stop tone_en", 32'(tone_en), 0);

    wr(32'd3001, 32'd2);
    wr(32'd3000, 32'd1);
    repeat (14) tick();
    wr(32'd3000, 32'd1);
    repeat (19) tick();
    chk("restart still on", 32'(tone_en), 1);
    tick();
    chk("restart expired", 32'(tone_en), 0);

    addr = 32'd3002; wr_data = 32'h7FFF; rd_en = 1'b1; wr_en = 1'b1;
    tick();
    rd_en = 1'b0; wr_en = 1'b0;
    chk("collision led", 32'(led), 32'h7FFF);
    chk("collision hit", 32'(hit), 0);
    chk("collision rd_data", rd_data, 0);
    rd(32'd3002, d, h);  chk("led read", d, 32'h7FFF);

    wr(32'd3001, 32'd5);
    wr(32'd3000, 32'd3);
    repeat (12) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid reset tone", 32'(tone), 0);
    chk("mid reset tone_en", 32'(tone_en), 0);
    rd(32'd3001, d, h);
    chk("mid reset dur", d, 0);
    chk("mid reset dur hit", 32'(h), 1);

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mmio_io_bridge.md
Name: mmio_io_bridge

Overview:
- Parametrised memory-mapped I/O peripheral on the processor data-memory bus. Replaces the ad-hoc address compares in the top level.
- Provides:
  - debounced input channels, readable live or as sticky clear-on-read edge flags
  - LFSR random source
  - tone register with an auto-off duration timer
  - LED register
- Top level muxes rd_data in place of RAM q_dmem whenever hit=1.

Parameters:
- N_IN, 4: number of input channels.
- DEBOUNCE, 250000: stable cycles required before an input change is accepted. Minimum 1.
- RAND_W, 4: width of the random value returned; must be ≤16.
- LFSR_SEED, 16'hACE1: reset seed; must be nonzero.
- TONE_W, 4: tone code width.
- LED_W, 15: LED register width.
- TICK_DIV, 50000: clock cycles per duration tick (1 ms at 50 MHz).
- DUR_W, 16: duration register width.
- IN_ADDR, 1000; EDGE_ADDR, 1001; RAND_ADDR, 2000; TONE_ADDR, 3000; DUR_ADDR, 3001; LED_ADDR, 3002; STAT_ADDR, 3003: decimal word addresses.

Ports:
- clock  in  1  sole clock (50 MHz domain).
- reset  in  1  synchronous, active-high.
- addr  in  32  data-memory address.
- rd_en  in  1  load strobe.
- wr_en  in  1  store strobe.
- wr_data  in  32  store data.
- rd_data  out  32  registered read data, zero-extended.
- hit  out  1  registered; 1 when rd_data is sourced by this block.
- in_raw  in  N_IN  asynchronous button/header inputs.
- tone  out  TONE_W  current tone code.
- tone_en  out  1  audio amplifier enable.
- led  out  LED_W  LED register.

Behaviour:
- Reset: rd_data=0, hit=0, tone=0, tone_en=0, led=0. Edge flags=0, debounced state=0, duration=0, timers=0, LFSR=LFSR_SEED. Applies mid-tone and mid-debounce.
- Input path:
  - in_raw passes through a 2-FF synchroniser per channel.
  - Per-channel counter: cleared while synced value == debounced value; otherwise increments.
  - On reaching DEBOUNCE, the debounced value takes the synced value and the counter clears.
  - A 0→1 debounced transition sets that channel's edge flag.
- LFSR: 16-bit Galois, taps mask 16'hB400, advances every cycle. Never zero.
- Reads:
  - A read is rd_en=1 and wr_en=0 at cycle t.
  - At t+1, hit=1 if addr matched a read address, else hit=0 and rd_data=0. Single-cycle latency, same as RAM.
  - Read values, sampled at t:
    - IN_ADDR: debounced state.
    - EDGE_ADDR: edge flags.
    - RAND_ADDR: LFSR[RAND_W-1:0].
    - TONE_ADDR: tone.
    - DUR_ADDR: duration register.
    - LED_ADDR: led.
    - STAT_ADDR: bit0=tone_en, bit1=timer active.
- EDGE_ADDR read clears the flags returned. An edge arriving in the same cycle t is kept set.
- Writes (wr_en=1), effective at t+1:
  - TONE_ADDR: tone=wr_data[TONE_W-1:0], tone_en=(that value≠0).
    - If nonzero and the duration register ≠0: load tick counter=duration, prescaler=0, timer active.
    - If zero: timer stops.
    - A nonzero write while active restarts the timer.
  - DUR_ADDR: duration=wr_data[DUR_W-1:0]. Does not affect a running timer.
  - LED_ADDR: led=wr_data[LED_W-1:0].
  - Other addresses: ignored.
- Timer:
  - While active, the prescaler counts 0..TICK_DIV-1. On wrap, the tick counter decrements.
  - When the counter reaches 0: tone=0, tone_en=0, timer inactive, all in the same edge.
  - Duration 0 means the tone holds until rewritten.
- rd_en and wr_en both 1: write performed, read ignored (hit=0, rd_data=0).
- Address matching uses the full 32 bits. No aliasing.

Test Plan:
1. Reset (DEBOUNCE=4, TICK_DIV=10): after reset, tone=0, tone_en=0, led=0, hit=0. Read RAND_ADDR → rd_data ≤15, hit=1 next cycle. Successive reads give a non-constant sequence.
2. Debounce: in_raw[2] high for 3 cycles, then low → IN read=0, no edge. Held high ≥2+4 cycles → IN read=4'b0100, EDGE read=4'b0100. Second EDGE read=0.
3. Edge race: edge on ch0 lands in the same cycle as an EDGE read that returns 4'b0010 → next EDGE read=4'b0001.
4. Timer: write DUR=3, then TONE=5 → tone=5, tone_en=1 for exactly 30 cycles, then 0. STAT read mid-tone=2'b11, after expiry=0.
5. Restart/stop: DUR=0, TONE=9 → held >1000 cycles. Write TONE=0 → tone_en=0 next cycle. DUR=2, TONE=1, rewrite TONE=1 at cycle 15 → expiry at cycle 35.
6. Collision and reset: rd_en=wr_en=1 at LED_ADDR with data 0x7FFF → led=0x7FFF, hit=0. Reset asserted mid-timer → tone=0, DUR read=0.
